dmem_arbiter: RTL

Two-port arbiter and access sequencer in front of the data memory. Shares the single word-wide data memory between the core load/store unit and a DMA/debug port. Converts RISC-V funct3-encoded byte/half/word accesses into word addresses, byte-lane write enables and sign/zero-extended load data. Sits between the core/DMA request ports and the memory primitive, replacing direct datapath-to-memory wiring.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_lane.sv | 50 +++++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: funct3 access codes, FSM states, port ids.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        PORT_CORE,
        PORT_DMA
    } port_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Unsigned codes only exist for loads; any unknown code is a word access.
    function automatic size_e access_size(input logic we, input logic [2:0] f3);
        if (f3 == F3_B || (!we && f3 == F3_BU)) return SZ_B;
        if (f3 == F3_H || (!we && f3 == F3_HU)) return SZ_H;
        return SZ_W;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: write enables, replicated store data, misalignment and load extension.
// Purely combinational, zero latency, no flow control.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  wr_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o
);

    size_e       size;
    logic        unsigned_ld;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        size         = access_size(we_i, funct3_i);
        unsigned_ld  = funct3_i[2];
        byte_v       = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v       = mem_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        wr_o         = 4'b0000;
        wdata_o      = wdata_i;
        misaligned_o = 1'b0;
        rdata_o      = mem_rdata_i;
        case (size)
            SZ_B: begin
                wr_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_ld ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                misaligned_o = addr_lo_i[0];
                wr_o         = addr_lo_i[0] ? 4'b0000 : (4'b0011 << {addr_lo_i[1], 1'b0});
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = unsigned_ld ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                misaligned_o = |addr_lo_i;
                wr_o         = (|addr_lo_i) ? 4'b0000 : 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing one word-wide data memory between core and DMA.
// Store: gnt 1 cycle then resp; load: gnt, read, resp (3 cycles); losers hold req until gnt.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic                  core_gnt,
    output logic                  core_resp,
    output logic                  core_err,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    input  logic [2:0]            dma_funct3,
    output logic                  dma_gnt,
    output logic                  dma_resp,
    output logic                  dma_err,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wr,
    input  logic [31:0]           mem_rdata
);

    state_e                state_q, state_d;
    port_e                 last_q, last_d;
    port_e                 port_q, port_d;
    port_e                 resp_port_q, resp_port_d;
    port_e                 win;
    logic                  we_q, we_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  resp_q, resp_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]     dma_rdata_q, dma_rdata_d;

    logic [3:0]            lane_wr;
    logic [31:0]           lane_wdata;
    logic                  lane_misaligned;
    logic [31:0]           lane_rdata;
    logic                  in_access;

    dmem_lane u_lane (
        .we_i         (we_q),
        .funct3_i     (f3_q),
        .addr_lo_i    (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .mem_rdata_i  (mem_rdata),
        .wr_o         (lane_wr),
        .wdata_o      (lane_wdata),
        .misaligned_o (lane_misaligned),
        .rdata_o      (lane_rdata)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        port_d       = port_q;
        resp_port_d  = resp_port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        resp_d       = 1'b0;
        err_d        = 1'b0;
        core_rdata_d = core_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        // On a tie the port that did not win last time goes first.
        if (core_req && dma_req) win = (last_q == PORT_DMA) ? PORT_CORE : PORT_DMA;
        else                     win = core_req ? PORT_CORE : PORT_DMA;

        case (state_q)
            IDLE: begin
                if (core_req || dma_req) begin
                    port_d  = win;
                    last_d  = win;
                    we_d    = (win == PORT_CORE) ? core_we     : dma_we;
                    addr_d  = (win == PORT_CORE) ? core_addr   : dma_addr;
                    wdata_d = (win == PORT_CORE) ? core_wdata  : dma_wdata;
                    f3_d    = (win == PORT_CORE) ? core_funct3 : dma_funct3;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (lane_misaligned || we_q) begin
                    state_d     = IDLE;
                    resp_d      = 1'b1;
                    resp_port_d = port_q;
                    err_d       = lane_misaligned;
                    if (lane_misaligned && port_q == PORT_CORE) core_rdata_d = '0;
                    if (lane_misaligned && port_q == PORT_DMA)  dma_rdata_d  = '0;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d     = IDLE;
                resp_d      = 1'b1;
                resp_port_d = port_q;
                if (port_q == PORT_CORE) core_rdata_d = lane_rdata;
                else                     dma_rdata_d  = lane_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= PORT_DMA;
            port_q       <= PORT_CORE;
            resp_port_q  <= PORT_CORE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            f3_q         <= '0;
            resp_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            port_q       <= port_d;
            resp_port_q  <= resp_port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            core_rdata_q <= core_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Memory-side outputs decode straight from state so a reset kills mem_wr immediately.
    assign in_access  = (state_q == ACCESS);
    assign mem_addr   = in_access ? 32'({addr_q[DM_ADDRESS-1:2], 2'b00}) : 32'b0;
    assign mem_wr     = (in_access && we_q) ? lane_wr : 4'b0000;
    assign mem_wdata  = (in_access && we_q) ? lane_wdata : 32'b0;

    assign core_gnt   = in_access && (port_q == PORT_CORE);
    assign dma_gnt    = in_access && (port_q == PORT_DMA);
    assign core_resp  = resp_q && (resp_port_q == PORT_CORE);
    assign dma_resp   = resp_q && (resp_port_q == PORT_DMA);
    assign core_err   = err_q && (resp_port_q == PORT_CORE);
    assign dma_err    = err_q && (resp_port_q == PORT_DMA);
    assign core_rdata = core_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule
